rgb_pwm_ctrl: RTL and testbench

Register-mapped controller that sequences and drives the iCE40 RGB LED current driver primitive. It owns the driver's enable pins, CURREN and RGBLEDEN, and powers them up and down in the order the hard IP needs. It generates three glitch-free PWM streams on RGB0PWM..RGB2PWM from per-channel duty registers, which software writes through the standard core bus interface.

---
 rtl/rgb_pwm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_ctrl.sv
// Register-mapped sequencer for the iCE40 RGB LED driver: orders CURREN/RGBLEDEN power-up and
// power-down and generates three glitch-free PWM streams from shadowed duty registers.
module rgb_pwm_ctrl #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        curren,
    output logic        rgbleden,
    output logic        rgb0_pwm,
    output logic        rgb1_pwm,
    output logic        rgb2_pwm
);

    localparam logic [PWM_BITS-1:0] PWM_MAX     = '1;
    localparam logic [15:0]         SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRun,
        StShutdown
    } state_e;

    state_e                     state_q, state_d;
    logic                       ctrl_en_q, ctrl_en_d;
    logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
    logic [2:0][PWM_BITS-1:0]   shadow_q, shadow_d;
    logic [15:0]                settle_ctr_q, settle_ctr_d;
    logic [PWM_BITS-1:0]        pwm_ctr_q, pwm_ctr_d;
    logic                       curren_q, curren_d;
    logic                       rgbleden_q, rgbleden_d;
    logic [2:0]                 pwm_q, pwm_d;
    logic                       load_shadow;
    logic                       running;
    logic                       unused_wdata;

    assign running      = (state_q == StRun);
    assign ready        = cs;
    assign unused_wdata = ^write_data;

    assign curren   = curren_q;
    assign rgbleden = rgbleden_q;
    assign rgb0_pwm = pwm_q[0];
    assign rgb1_pwm = pwm_q[1];
    assign rgb2_pwm = pwm_q[2];

    // Register file writes; duty_d is also what the shadow load sees (write-through).
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        duty_d    = duty_q;
        if (cs && we) begin
            case (address)
                2'd0:    ctrl_en_d = write_data[0];
                2'd1:    duty_d[0] = write_data[PWM_BITS-1:0];
                2'd2:    duty_d[1] = write_data[PWM_BITS-1:0];
                default: duty_d[2] = write_data[PWM_BITS-1:0];
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (cs && !we) begin
            case (address)
                2'd0:    read_data = {30'b0, running, ctrl_en_q};
                2'd1:    read_data = 32'(duty_q[0]);
                2'd2:    read_data = 32'(duty_q[1]);
                default: read_data = 32'(duty_q[2]);
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_ctr_d = settle_ctr_q;
        pwm_ctr_d    = pwm_ctr_q;
        curren_d     = 1'b0;
        rgbleden_d   = 1'b0;
        load_shadow  = 1'b0;

        unique case (state_q)
            StIdle: begin
                settle_ctr_d = '0;
                pwm_ctr_d    = '0;
                if (ctrl_en_q) begin
                    state_d  = StSettle;
                    curren_d = 1'b1;
                end
            end
            StSettle: begin
                if (!ctrl_en_q) begin
                    state_d      = StIdle;
                    settle_ctr_d = '0;
                end else if (settle_ctr_q == SETTLE_LAST) begin
                    state_d      = StRun;
                    curren_d     = 1'b1;
                    rgbleden_d   = 1'b1;
                    settle_ctr_d = '0;
                    pwm_ctr_d    = '0;
                    load_shadow  = 1'b1;
                end else begin
                    curren_d     = 1'b1;
                    settle_ctr_d = settle_ctr_q + 16'd1;
                end
            end
            StRun: begin
                if (!ctrl_en_q) begin
                    // Drop RGBLEDEN and PWM first; CURREN follows one cycle later.
                    state_d   = StShutdown;
                    curren_d  = 1'b1;
                    pwm_ctr_d = '0;
                end else begin
                    curren_d    = 1'b1;
                    rgbleden_d  = 1'b1;
                    pwm_ctr_d   = pwm_ctr_q + PWM_BITS'(1);
                    load_shadow = (pwm_ctr_q == PWM_MAX);
                end
            end
            StShutdown: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        pwm_d    = '0;
        if (load_shadow) begin
            shadow_d = duty_d;
        end
        if (state_d == StRun) begin
            for (int i = 0; i < 3; i++) begin
                pwm_d[i] = (pwm_ctr_d < shadow_d[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ctrl_en_q    <= 1'b0;
            duty_q       <= '0;
            shadow_q     <= '0;
            settle_ctr_q <= '0;
            pwm_ctr_q    <= '0;
            curren_q     <= 1'b0;
            rgbleden_q   <= 1'b0;
            pwm_q        <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_en_q    <= ctrl_en_d;
            duty_q       <= duty_d;
            shadow_q     <= shadow_d;
            settle_ctr_q <= settle_ctr_d;
            pwm_ctr_q    <= pwm_ctr_d;
            curren_q     <= curren_d;
            rgbleden_q   <= rgbleden_d;
            pwm_q        <= pwm_d;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: power sequencing, PWM duty counts, glitch-free duty
// updates, disable/re-enable paths and asynchronous reset.
module tb_rgb_pwm_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [1:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        curren;
    logic        rgbleden;
    logic        rgb0_pwm;
    logic        rgb1_pwm;
    logic        rgb2_pwm;

    int checks   = 0;
    int failures = 0;

    rgb_pwm_ctrl #(
        .PWM_BITS      (8),
        .SETTLE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .curren     (curren),
        .rgbleden   (rgbleden),
        .rgb0_pwm   (rgb0_pwm),
        .rgb1_pwm   (rgb1_pwm),
        .rgb2_pwm   (rgb2_pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the following posedge is the write edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; write_data = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; we = 1'b0; address = a;
        #1;
        d = read_data;
        check("ready_on_access", {31'b0, ready}, 32'd1);
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Counts negedges until rgbleden is seen high; stops at a bound of 40.
    task automatic wait_run(output int n, output int curren_lows);
        n = 0;
        curren_lows = 0;
        while (!rgbleden && n < 40) begin
            if (!curren) curren_lows++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int n, lows, c0, c1, c2, edges;
        logic prev;

        reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
        tick(3);
        check("reset_outputs", {27'b0, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'd0);
        reset_n = 1'b1;
        tick(1);
        check("rdata_idle", read_data, 32'd0);
        check("ready_idle", {31'b0, ready}, 32'd0);
        bus_read(2'd0, rd);
        check("ctrl_after_reset", rd, 32'h0);
        bus_read(2'd2, rd);
        check("duty1_after_reset", rd, 32'h0);

        // Duty programming; upper write_data bits must be dropped.
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd64);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        check("duty1_readback", rd, 32'd64);
        bus_read(2'd3, rd);
        check("duty2_truncated", rd, 32'hFF);

        // Power-up: CURREN one edge after the write edge, RGBLEDEN 16 edges after that.
        bus_write(2'd0, 32'd1);
        check("curren_not_yet", {31'b0, curren}, 32'd0);
        tick(1);
        check("curren_rise", {31'b0, curren}, 32'd1);
        check("rgbleden_low_settle", {31'b0, rgbleden}, 32'd0);
        wait_run(n, lows);
        check("settle_edges", n, 32'd16);
        check("curren_held_settle", lows, 32'd0);
        check("pwm_at_entry", {29'b0, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'b110);
        bus_read(2'd0, rd);
        check("ctrl_running", rd, 32'h3);

        // Two full periods (pwm_ctr now 1).
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 512; i++) begin
            c0 += int'(rgb0_pwm); c1 += int'(rgb1_pwm); c2 += int'(rgb2_pwm);
            @(negedge clk);
        end
        check("highs_duty0", c0, 32'd0);
        check("highs_duty64", c1, 32'd128);
        check("highs_duty255", c2, 32'd510);

        // Mid-period change at pwm_ctr=10: current period keeps 64, next gets 200.
        tick(9);
        bus_write(2'd2, 32'd200);
        c1 = 0; edges = 0; prev = rgb1_pwm;
        for (int i = 0; i < 245; i++) begin
            c1 += int'(rgb1_pwm);
            if (rgb1_pwm != prev) edges++;
            prev = rgb1_pwm;
            @(negedge clk);
        end
        check("mid_period_old_duty", c1, 32'd53);
        c1 = 0;
        for (int i = 0; i < 256; i++) begin
            c1 += int'(rgb1_pwm);
            if (rgb1_pwm != prev) edges++;
            prev = rgb1_pwm;
            @(negedge clk);
        end
        check("next_period_new_duty", c1, 32'd200);
        check("mid_period_edges", edges, 32'd3);

        // Write on the wrap-load cycle (pwm_ctr=255) applies to the very next period.
        tick(255);
        bus_write(2'd1, 32'd3);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 256; i++) begin
            c0 += int'(rgb0_pwm); c1 += int'(rgb1_pwm);
            @(negedge clk);
        end
        check("wrap_write_through", c0, 32'd3);
        check("wrap_other_channel", c1, 32'd200);

        // Disable from RUN.
        bus_write(2'd0, 32'd0);
        check("run_until_edge", {31'b0, rgbleden}, 32'd1);
        tick(1);
        check("shutdown_rgbleden", {31'b0, rgbleden}, 32'd0);
        check("shutdown_pwm", {29'b0, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'd0);
        check("shutdown_curren", {31'b0, curren}, 32'd1);
        tick(1);
        check("idle_curren", {31'b0, curren}, 32'd0);

        // Abort during SETTLE.
        bus_write(2'd0, 32'd1);
        tick(1);
        check("abort_settle_entry", {31'b0, curren}, 32'd1);
        bus_read(2'd0, rd);
        check("ctrl_settling", rd, 32'h1);
        tick(3);
        bus_write(2'd0, 32'd0);
        check("abort_curren_hold", {31'b0, curren}, 32'd1);
        tick(1);
        check("abort_idle", {31'b0, curren}, 32'd0);
        c0 = 0;
        for (int i = 0; i < 30; i++) begin
            c0 += int'(rgbleden) + int'(curren);
            @(negedge clk);
        end
        check("abort_stays_off", c0, 32'd0);

        // Re-enable in the SHUTDOWN cycle.
        bus_write(2'd0, 32'd1);
        tick(1);
        wait_run(n, lows);
        check("reenter_run", n, 32'd16);
        bus_write(2'd0, 32'd0);
        tick(1);
        check("sd_curren", {31'b0, curren}, 32'd1);
        check("sd_rgbleden", {31'b0, rgbleden}, 32'd0);
        bus_write(2'd0, 32'd1);
        check("sd_to_idle", {31'b0, curren}, 32'd0);
        tick(1);
        check("reenable_settle", {31'b0, curren}, 32'd1);
        wait_run(n, lows);
        check("reenable_full_settle", n, 32'd16);
        check("reenable_curren_held", lows, 32'd0);

        // Asynchronous reset mid-RUN.
        bus_write(2'd1, 32'h80);
        tick(260);
        n = 0;
        while (!rgb0_pwm && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_state", {29'b0, curren, rgbleden, rgb0_pwm}, 32'b111);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {27'b0, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd0, rd);
        check("ctrl_after_async_reset", rd, 32'h0);
        bus_read(2'd1, rd);
        check("duty0_after_async_reset", rd, 32'h0);
        tick(20);
        check("idle_after_reset", {27'b0, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
